// File: rtl/legv8_control_fsm.sv
// Multi-cycle LEGv8 control unit: sequences FETCH/EXEC and derives the datapath
// control word and immediate constant from the held instruction register.
module legv8_control_fsm #(
  parameter int CW_W    = 40,
  parameter int CONST_W = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        IR_out,
  input  logic [4:0]         status,
  input  logic [3:0]         current_status,
  output logic [CW_W-1:0]    ControlWord,
  output logic [CONST_W-1:0] constant,
  output logic [2:0]         state,
  output logic               halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC   = 3'd1,
    LOAD2  = 3'd2,
    BRTEST = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  state_t state_q, state_d;
  logic   zflag_q;

  // Immediate extension helpers; each returns a sign- or zero-extended constant.
  function automatic logic signed [CONST_W-1:0] sext_d9(input logic [8:0] v);
    return {{(CONST_W-9){v[8]}}, v};
  endfunction

  function automatic logic signed [CONST_W-1:0] sext_br26(input logic [25:0] v);
    return {{(CONST_W-28){v[25]}}, v, 2'b00};
  endfunction

  function automatic logic signed [CONST_W-1:0] sext_br19(input logic [18:0] v);
    return {{(CONST_W-21){v[18]}}, v, 2'b00};
  endfunction

  function automatic logic [CONST_W-1:0] zext_i12(input logic [11:0] v);
    return {{(CONST_W-12){1'b0}}, v};
  endfunction

  logic [10:0] op;
  logic is_add, is_sub, is_and, is_orr, is_rtype;
  logic is_addi, is_subi, is_ldur, is_stur, is_b, is_cbz, is_cbnz;

  assign op       = IR_out[31:21];
  assign is_add   = (op == 11'h458);
  assign is_sub   = (op == 11'h658);
  assign is_and   = (op == 11'h450);
  assign is_orr   = (op == 11'h550);
  assign is_rtype = is_add | is_sub | is_and | is_orr;
  assign is_addi  = (op[10:1] == 10'h244);
  assign is_subi  = (op[10:1] == 10'h344);
  assign is_ldur  = (op == 11'h7C2);
  assign is_stur  = (op == 11'h7C0);
  assign is_b     = (op[10:5] == 6'b000101);
  assign is_cbz   = (op[10:3] == 8'hB4);
  assign is_cbnz  = (op[10:3] == 8'hB5);

  // The latched flags are not consumed yet; keep them visibly terminated.
  logic unused_status;
  assign unused_status = ^{current_status, status[4:1]};

  logic [1:0]         dsel, pc_fs, size;
  logic               pc_en, b_sel, ir_ld, c0, mw, rw;
  logic [4:0]         fs, da, sa, sb;
  logic [CONST_W-1:0] const_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == BRTEST) zflag_q <= status[0];
    end
  end

  always_comb begin
    state_d = state_q;
    dsel    = 2'b00;
    pc_fs   = 2'b00;
    size    = 2'b00;
    pc_en   = 1'b0;
    b_sel   = 1'b0;
    ir_ld   = 1'b0;
    c0      = 1'b0;
    mw      = 1'b0;
    rw      = 1'b0;
    fs      = FS_AND;
    da      = 5'd0;
    sa      = 5'd0;
    sb      = 5'd0;
    const_d = '0;

    unique case (state_q)
      FETCH: begin
        dsel    = 2'b10;
        ir_ld   = 1'b1;
        pc_en   = 1'b1;
        state_d = EXEC;
      end
      // LOAD2 re-decodes the held LDUR so the word repeats with PC advancing.
      EXEC, LOAD2: begin
        size = 2'b11;
        if (is_b) begin
          pc_en   = 1'b1;
          pc_fs   = 2'b11;
          const_d = sext_br26(IR_out[25:0]);
          state_d = FETCH;
        end else if (is_cbz || is_cbnz) begin
          state_d = BRTEST;
        end else if (is_rtype || is_addi || is_subi) begin
          pc_en   = 1'b1;
          pc_fs   = 2'b01;
          rw      = 1'b1;
          da      = IR_out[4:0];
          sa      = IR_out[9:5];
          if (is_rtype) begin
            sb = IR_out[20:16];
            fs = is_add ? FS_ADD : is_sub ? FS_SUB : is_orr ? FS_ORR : FS_AND;
            c0 = is_sub;
          end else begin
            b_sel   = 1'b1;
            fs      = is_subi ? FS_SUB : FS_ADD;
            c0      = is_subi;
            const_d = zext_i12(IR_out[21:10]);
          end
          state_d = FETCH;
        end else if (is_ldur) begin
          dsel    = 2'b11;
          b_sel   = 1'b1;
          fs      = FS_ADD;
          rw      = 1'b1;
          da      = IR_out[4:0];
          sa      = IR_out[9:5];
          pc_en   = 1'b1;
          const_d = sext_d9(IR_out[20:12]);
          pc_fs   = (state_q == LOAD2) ? 2'b01 : 2'b00;
          state_d = (state_q == LOAD2) ? FETCH : LOAD2;
        end else if (is_stur) begin
          dsel    = 2'b01;
          b_sel   = 1'b1;
          fs      = FS_ADD;
          mw      = 1'b1;
          sa      = IR_out[9:5];
          sb      = IR_out[4:0];
          pc_en   = 1'b1;
          pc_fs   = 2'b01;
          const_d = sext_d9(IR_out[20:12]);
          state_d = FETCH;
        end else begin
          size    = 2'b00;
          state_d = HALT;
        end
      end
      // Zero test: ORR Rt with XZR, Z captured into zflag_q at the edge.
      BRTEST: begin
        size    = 2'b11;
        fs      = FS_ORR;
        sa      = IR_out[4:0];
        sb      = 5'd31;
        state_d = BRANCH;
      end
      BRANCH: begin
        size    = 2'b11;
        pc_en   = 1'b1;
        const_d = sext_br19(IR_out[23:5]);
        pc_fs   = ((is_cbz && zflag_q) || (is_cbnz && !zflag_q)) ? 2'b11 : 2'b01;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are forced quiet while reset is held so no partial write escapes.
  always_comb begin
    if (reset) begin
      ControlWord = '0;
      constant    = '0;
    end else begin
      ControlWord = {{(CW_W-33){1'b0}}, dsel, pc_fs, pc_en, b_sel, ir_ld, 1'b0,
                     fs, c0, size, mw, rw, da, sa, sb};
      constant    = const_d;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == HALT) && !reset;

endmodule
